// File: rtl/wb_master_if_if.sv
// Wishbone classic bus bundle between the CPU-side master adapter and a slave.
interface wb_master_if_if;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;
  logic [31:0] wishbone_data_i;
  logic        wishbone_ack_i;

  modport master (
    output wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o,
           wishbone_stb_o, wishbone_cyc_o,
    input  wishbone_data_i, wishbone_ack_i
  );

  modport slave (
    input  wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o,
           wishbone_stb_o, wishbone_cyc_o,
    output wishbone_data_i, wishbone_ack_i
  );
endinterface

// File: rtl/wb_master_if.sv
// CPU-pipeline to Wishbone classic master adapter (IDLE -> BUSY -> WAIT_FOR_STALL).
// Optional bus timeout abort is built only when WB_TIMEOUT_EN is defined.
module wb_master_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] cpu_data_o,
  output logic        stall_req_o,
  output logic        err_o,
  wb_master_if_if.master wb
);

  localparam logic [1:0] IDLE           = 2'd0;
  localparam logic [1:0] BUSY           = 2'd1;
  localparam logic [1:0] WAIT_FOR_STALL = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic        active_q;
  logic [31:0] read_buf;
  logic        start;
  logic        timeout_hit;
  logic        bus_end;

  assign start   = (state == IDLE) && cpu_ce_i && !flush_i;
  assign bus_end = (state == BUSY) && (flush_i || wb.wishbone_ack_i || timeout_hit);

`ifdef WB_TIMEOUT_EN
  logic [7:0] timeout_cnt;

  assign timeout_hit = (state == BUSY) && !wb.wishbone_ack_i &&
                       (timeout_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst || start)
      timeout_cnt <= '0;
    else if (state == BUSY && !wb.wishbone_ack_i)
      timeout_cnt <= timeout_cnt + 8'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = BUSY;
      BUSY: begin
        if (flush_i)
          state_next = IDLE;
        else if (wb.wishbone_ack_i || timeout_hit)
          state_next = stall_i ? WAIT_FOR_STALL : IDLE;
      end
      WAIT_FOR_STALL: if (flush_i || !stall_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // stb and cyc share one register so they can never disagree.
  always_ff @(posedge clk) begin
    if (!rst || bus_end) begin
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      addr_q   <= cpu_addr_i;
      data_q   <= cpu_data_i;
      we_q     <= cpu_we_i;
      sel_q    <= cpu_sel_i;
      active_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      read_buf <= '0;
    else if (state == BUSY && wb.wishbone_ack_i && !flush_i && !we_q)
      read_buf <= wb.wishbone_data_i;
    else if (state == WAIT_FOR_STALL && flush_i)
      read_buf <= '0;
  end

  assign wb.wishbone_addr_o = addr_q;
  assign wb.wishbone_data_o = data_q;
  assign wb.wishbone_we_o   = we_q;
  assign wb.wishbone_sel_o  = sel_q;
  assign wb.wishbone_stb_o  = active_q;
  assign wb.wishbone_cyc_o  = active_q;

  // A flush wins over both ack and timeout, so read data is never forwarded with it.
  always_comb begin
    stall_req_o = 1'b0;
    cpu_data_o  = '0;
    err_o       = 1'b0;
    if (rst) begin
      case (state)
        IDLE: stall_req_o = cpu_ce_i && !flush_i;
        BUSY: begin
          stall_req_o = !wb.wishbone_ack_i && !(timeout_hit && !flush_i);
          err_o       = timeout_hit && !flush_i;
          if (wb.wishbone_ack_i && !we_q && !flush_i)
            cpu_data_o = wb.wishbone_data_i;
        end
        WAIT_FOR_STALL: cpu_data_o = read_buf;
        default: ;
      endcase
    end
  end

endmodule
